// File: rtl/wlo_pkg.sv
// Shared types and helpers for the word-length-optimisation error collectors.
package wlo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WARMUP = 3'd1,
      ST_ACCUM  = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_DRAIN  = 3'd4
   } mse_state_t;

   // Widest accumulator/product the saturating adder can handle.
   localparam int SAT_MAX_W = 128;

   // Unsigned add, clamped to the all-ones value of an acc_w-bit register.
   function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] acc,
                                                    input logic [SAT_MAX_W-1:0] p,
                                                    input int                   acc_w);
      logic [SAT_MAX_W:0] sum;
      logic [SAT_MAX_W:0] lim;
      sum = {1'b0, acc} + {1'b0, p};
      lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
      return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/mse_lane.sv
// One error lane: difference, square, saturating sum of squares.
module mse_lane
   import wlo_pkg::*;
#(
   parameter int DW    = 29,
   parameter int ACC_W = 64
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic signed [DW-1:0] data_in_i,
   input  logic signed [DW-1:0] data_ref_i,
   output logic [ACC_W-1:0]     acc_o
);

   logic signed [DW:0]     diff_d, diff_q;
   logic signed [2*DW+1:0] diff_ext, prod_d;
   logic [2*DW+1:0]        prod_q;
   logic                   v1_q, v2_q;
   logic [ACC_W-1:0]       acc_d, acc_q;

   assign diff_d   = {data_in_i[DW-1], data_in_i} - {data_ref_i[DW-1], data_ref_i};
   assign diff_ext = {{(DW+1){diff_q[DW]}}, diff_q};
   assign prod_d   = diff_ext * diff_ext;
   assign acc_d    = ACC_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(prod_q), ACC_W));

   // v1/v2 track which pipeline slots carry a real sample.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         diff_q <= '0;
         prod_q <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         acc_q  <= '0;
      end else if (clr_i) begin
         diff_q <= '0;
         prod_q <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         acc_q  <= '0;
      end else begin
         diff_q <= diff_d;
         prod_q <= prod_d;
         v1_q   <= en_i;
         v2_q   <= v1_q;
         if (v2_q) acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mse_bank.sv
// Multi-lane sum-of-squared-error collector with one-channel-at-a-time result handshake.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_WARMUP | discarding samples while DSP pipelines fill
//   ST_ACCUM  | sampling NUM_SAMPLES inputs into the lanes
//   ST_FLUSH  | letting the last products reach the accumulators
//   ST_DRAIN  | presenting channel results over valid/ready
module mse_bank
   import wlo_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DW          = 29,
   parameter int ACC_W       = 64,
   parameter int NUM_SAMPLES = 1024,
   parameter int WARMUP      = 8,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         start,
   input  logic [NUM_CH-1:0][DW-1:0]    data_in,
   input  logic [NUM_CH-1:0][DW-1:0]    data_ref,
   output logic [ACC_W-1:0]             result_data,
   output logic [CH_W-1:0]              result_ch,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int CNT_TOP = (NUM_SAMPLES > WARMUP) ? NUM_SAMPLES : WARMUP;
   localparam int CNT_W   = $clog2(CNT_TOP + 1);
   localparam logic [CNT_W-1:0] SAMP_LAST  = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(1);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

   mse_state_t              state_d, state_q;
   logic [CNT_W-1:0]        cnt_d, cnt_q;
   logic [CH_W-1:0]         ch_d, ch_q;
   logic                    done_d, done_q;
   logic                    clr;
   logic [ACC_W-1:0]        last_q;
   logic [NUM_CH-1:0][ACC_W-1:0] acc_arr;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      mse_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
         .clk_i      (clk),
         .rstn_i     (rstn),
         .clr_i      (clr),
         .en_i       (state_q == ST_ACCUM),
         .data_in_i  (data_in[g]),
         .data_ref_i (data_ref[g]),
         .acc_o      (acc_arr[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // The done cycle is still IDLE but must not accept a new run.
            if (start && !done_q) begin
               clr = 1'b1;
               if (WARMUP > 0) begin
                  state_d = ST_WARMUP;
                  cnt_d   = WARM_LAST;
               end else begin
                  state_d = ST_ACCUM;
                  cnt_d   = SAMP_LAST;
               end
            end
         end
         ST_WARMUP: begin
            if (cnt_q == '0) begin
               state_d = ST_ACCUM;
               cnt_d   = SAMP_LAST;
            end else cnt_d = cnt_q - 1'b1;
         end
         ST_ACCUM: begin
            if (cnt_q == '0) begin
               state_d = ST_FLUSH;
               cnt_d   = FLUSH_LAST;
            end else cnt_d = cnt_q - 1'b1;
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_DRAIN;
               ch_d    = '0;
            end else cnt_d = cnt_q - 1'b1;
         end
         ST_DRAIN: begin
            if (result_ready) begin
               if (ch_q == CH_LAST) begin
                  state_d = ST_IDLE;
                  ch_d    = '0;
                  done_d  = 1'b1;
               end else ch_d = ch_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         done_q  <= 1'b0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         done_q  <= done_d;
         if (state_q == ST_DRAIN) last_q <= acc_arr[ch_q];
      end
   end

   // Accumulators are cleared on the next start, so the idle output comes from last_q.
   assign result_data  = (state_q == ST_DRAIN) ? acc_arr[ch_q] : last_q;
   assign result_ch    = ch_q;
   assign result_valid = (state_q == ST_DRAIN);
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_mse_bank.sv
// Scoreboard bench for mse_bank: a 64-bit and a 16-bit (saturating) instance driven in lockstep.
module tb_mse_bank;

   localparam int NUM_CH  = 2;
   localparam int DW      = 8;
   localparam int NS      = 4;
   localparam int WU      = 2;
   localparam int RUN_LEN = WU + NS;
   localparam int LAT     = 1 + WU + NS + 2;

   typedef struct {
      int     ch;
      longint data;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic ready = 1'b0;
   logic [NUM_CH-1:0][DW-1:0] din, dref;

   logic [63:0] rd_a;
   logic [15:0] rd_b;
   logic [0:0]  ch_a, ch_b;
   logic        v_a, v_b, busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   mse_bank #(.NUM_CH(NUM_CH), .DW(DW), .ACC_W(64), .NUM_SAMPLES(NS), .WARMUP(WU)) u_a (
      .clk(clk), .rstn(rstn), .start(start), .data_in(din), .data_ref(dref),
      .result_data(rd_a), .result_ch(ch_a), .result_valid(v_a), .result_ready(ready),
      .busy(busy_a), .done(done_a));

   mse_bank #(.NUM_CH(NUM_CH), .DW(DW), .ACC_W(16), .NUM_SAMPLES(NS), .WARMUP(WU)) u_b (
      .clk(clk), .rstn(rstn), .start(start), .data_in(din), .data_ref(dref),
      .result_data(rd_b), .result_ch(ch_b), .result_valid(v_b), .result_ready(ready),
      .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: any presented result must match the head of the scoreboard; pop on acceptance.
   always @(negedge clk) begin
      if (rstn) begin
         if (v_a) begin
            if (q_a.size() == 0) chk("unexpected_valid_a", 1, 0);
            else begin
               chk("data_a", rd_a, q_a[0].data);
               chk("ch_a", ch_a, q_a[0].ch);
               if (ready) void'(q_a.pop_front());
            end
         end
         if (v_b) begin
            if (q_b.size() == 0) chk("unexpected_valid_b", 1, 0);
            else begin
               chk("data_b", rd_b, q_b[0].data);
               chk("ch_b", ch_b, q_b[0].ch);
               if (ready) void'(q_b.pop_front());
            end
         end
         if (done_a) done_cnt_a++;
         if (done_b) done_cnt_b++;
      end
   end

   task automatic drive_garbage();
      for (int c = 0; c < NUM_CH; c++) begin
         din[c]  = DW'($urandom);
         dref[c] = DW'($urandom);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, v_a, 0);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_done"}, done_a, 0);
      chk({tag, "_data_a"}, rd_a, 0);
      chk({tag, "_data_b"}, rd_b, 0);
      chk({tag, "_ch"}, ch_a, 0);
   endtask

   // mode 0 zero error, 1 constant error, 2 warm-up discard, 3 saturation, 4 random
   task automatic run(input int mode, input bit bp);
      int     in_v [RUN_LEN][NUM_CH];
      int     ref_v[RUN_LEN][NUM_CH];
      longint sum;
      int     first, n, d0a, d0b, e;
      exp_t   x;
      for (int k = 0; k < RUN_LEN; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            case (mode)
               0: begin in_v[k][c] = 37; ref_v[k][c] = 37; end
               1: begin
                  in_v[k][c]  = (c == 0) ? 10 : -128;
                  ref_v[k][c] = (c == 0) ? 7  : 127;
               end
               2: begin
                  if (k < WU) begin in_v[k][c] = 100; ref_v[k][c] = 0; end
                  else begin
                     in_v[k][c]  = int'($urandom_range(0, 255)) - 128;
                     ref_v[k][c] = in_v[k][c];
                  end
               end
               3: begin
                  in_v[k][c]  = (c == 0) ? 5 : -128;
                  ref_v[k][c] = (c == 0) ? 4 : 127;
               end
               default: begin
                  in_v[k][c]  = int'($urandom_range(0, 255)) - 128;
                  ref_v[k][c] = int'($urandom_range(0, 255)) - 128;
               end
            endcase
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         sum = 0;
         for (int k = WU; k < RUN_LEN; k++) begin
            e = in_v[k][c] - ref_v[k][c];
            sum += longint'(e * e);
         end
         x.ch = c;
         x.data = sum;
         q_a.push_back(x);
         x.data = (sum > 65535) ? 65535 : sum;
         q_b.push_back(x);
      end
      d0a = done_cnt_a;
      d0b = done_cnt_b;
      ready = !bp;
      start = 1'b1;
      drive_garbage();
      first = 0;
      for (int k = 1; k <= 40 && first == 0; k++) begin
         @(posedge clk); #1;
         start = bp && (k == 4);
         if (k <= RUN_LEN) begin
            for (int c = 0; c < NUM_CH; c++) begin
               din[c]  = DW'(in_v[k-1][c]);
               dref[c] = DW'(ref_v[k-1][c]);
            end
         end else drive_garbage();
         if (v_a) first = k;
      end
      chk("first_valid_latency", first, LAT);
      n = 0;
      while (busy_a && n < 40) begin
         ready = !(bp && n < 5);
         start = bp && (n == 2);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("drain_ends_busy_low", busy_a, 0);
      chk("done_pulse_a", done_a, 1);
      chk("done_pulse_b", done_b, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_in_done_cycle_ignored", busy_a, 0);
      chk("done_one_cycle", done_a, 0);
      chk("done_count_a", done_cnt_a - d0a, 1);
      chk("done_count_b", done_cnt_b - d0b, 1);
      chk("idle_ch_zero", ch_a, 0);
      chk("scoreboard_a_empty", q_a.size(), 0);
      chk("scoreboard_b_empty", q_b.size(), 0);
      q_a.delete();
      q_b.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=stuck required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      din  = '0;
      dref = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      run(0, 1'b0);
      run(1, 1'b0);
      run(2, 1'b0);
      run(3, 1'b1);
      for (int i = 0; i < 4; i++) run(4, i[0]);
      run(1, 1'b0);

      start = 1'b1;
      drive_garbage();
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         drive_garbage();
      end
      chk("abort_in_accum_busy", busy_a, 1);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("midrun_reset");
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("no_done_after_abort", done_a, 0);
      run(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
